// File: rtl/spi_cmd_router.sv
// Routes 32-bit SPI command words to a response channel selected by opcode,
// then returns one registered response or error word per accepted command.
module spi_cmd_router #(
    parameter int                     NUM_CH    = 4,
    parameter int                     DATA_W    = 32,
    parameter int                     OP_W      = 4,
    parameter logic [NUM_CH*OP_W-1:0] CH_LO     = {4'd8, 4'd6, 4'd4, 4'd1},
    parameter logic [NUM_CH-1:0]      IMMEDIATE = '0,
    parameter int                     TIMEOUT   = 255,
    parameter logic [DATA_W-1:0]      ERR_WORD  = 32'hFFFF_0000
) (
    input  logic                     clk,
    input  logic                     rest,
    input  logic [DATA_W-1:0]        cmd_in,
    input  logic                     cmd_valid,
    output logic                     cmd_busy,
    output logic [DATA_W-1:0]        ch_cmd,
    output logic [NUM_CH-1:0]        ch_cmd_valid,
    input  logic [NUM_CH*DATA_W-1:0] ch_rsp_data,
    input  logic [NUM_CH-1:0]        ch_rsp_valid,
    output logic [DATA_W-1:0]        rsp_out,
    output logic                     rsp_valid,
    output logic [1:0]               err_code,
    output logic [7:0]               err_cnt
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] ERR_UNMAPPED = {ERR_WORD[DATA_W-1:2], 2'd1};
    localparam logic [DATA_W-1:0] ERR_TIMEOUT  = {ERR_WORD[DATA_W-1:2], 2'd2};

    typedef enum logic [1:0] {
        S_IDLE,
        S_DISPATCH,
        S_WAIT
    } routerState;

    routerState       state;
    logic [CH_W-1:0]  curCh;
    logic [CNT_W-1:0] cnt;

    logic [OP_W-1:0]   opcode;
    logic              hit;
    logic [CH_W-1:0]   hitCh;
    logic [DATA_W-1:0] selData;
    logic              selValid;
    logic              selImm;

    logic       newCmd;
    logic       overrun;
    logic       timedOut;
    logic       errDone;
    logic [1:0] errInc;
    logic [8:0] errSum;
    logic [7:0] errNext;

    assign opcode = cmd_in[DATA_W-1 -: OP_W];

    // Ascending scan leaves the highest channel whose base is not above opcode.
    always_comb begin
        hit   = 1'b0;
        hitCh = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (opcode >= CH_LO[i*OP_W +: OP_W]) begin
                hit   = 1'b1;
                hitCh = CH_W'(i);
            end
        end
    end

    always_comb begin
        selData  = '0;
        selValid = 1'b0;
        selImm   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (curCh == CH_W'(i)) begin
                selData  = ch_rsp_data[i*DATA_W +: DATA_W];
                selValid = ch_rsp_valid[i];
                selImm   = IMMEDIATE[i];
            end
        end
    end

    assign newCmd   = cmd_valid && (state == S_IDLE);
    assign overrun  = cmd_valid && (state != S_IDLE);
    assign timedOut = (state == S_WAIT) && !selValid && (cnt == CNT_LAST);
    assign errDone  = (newCmd && !hit) || timedOut;

    // Overrun and error completion can coincide, so the step is 0..2.
    assign errInc  = {1'b0, overrun} + {1'b0, errDone};
    assign errSum  = {1'b0, err_cnt} + {7'd0, errInc};
    assign errNext = errSum[8] ? 8'hFF : errSum[7:0];

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            state        <= S_IDLE;
            curCh        <= '0;
            cnt          <= '0;
            cmd_busy     <= 1'b0;
            ch_cmd       <= '0;
            ch_cmd_valid <= '0;
            rsp_out      <= '0;
            rsp_valid    <= 1'b0;
            err_code     <= 2'd0;
            err_cnt      <= 8'd0;
        end else begin
            rsp_valid    <= 1'b0;
            ch_cmd_valid <= '0;
            err_cnt      <= errNext;
            unique case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (hit) begin
                            ch_cmd       <= cmd_in;
                            curCh        <= hitCh;
                            ch_cmd_valid <= NUM_CH'(1) << hitCh;
                            cmd_busy     <= 1'b1;
                            state        <= S_DISPATCH;
                        end else begin
                            rsp_out   <= ERR_UNMAPPED;
                            err_code  <= 2'd1;
                            rsp_valid <= 1'b1;
                        end
                    end
                end
                S_DISPATCH: begin
                    if (selImm || selValid) begin
                        rsp_out   <= selData;
                        err_code  <= 2'd0;
                        rsp_valid <= 1'b1;
                        cmd_busy  <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        cnt   <= '0;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A response in the final wait cycle beats the timeout.
                    if (selValid) begin
                        rsp_out   <= selData;
                        err_code  <= 2'd0;
                        rsp_valid <= 1'b1;
                        cmd_busy  <= 1'b0;
                        state     <= S_IDLE;
                    end else if (cnt == CNT_LAST) begin
                        rsp_out   <= ERR_TIMEOUT;
                        err_code  <= 2'd2;
                        rsp_valid <= 1'b1;
                        cmd_busy  <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    cmd_busy <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
